// File: rtl/ddr3_cmd_responder.sv
// ddr3_cmd_responder: device-side DDR3 command/data responder for emulation.
// It decodes commands, tracks the open row of each bank, stores write bursts,
// and returns read bursts CL cycles after the RD command.
// Optional build macro: DDR3_RESP_TIMING_CHK_EN adds per-bank ACT-to-RD/WR
// (tRCD) spacing checks.
module ddr3_cmd_responder #(
  parameter int DW        = 16,
  parameter int CL        = 5,
  parameter int CWL       = 4,
  parameter int TRCD      = 3,
  parameter int MEM_ROW_W = 4,
  parameter int MEM_COL_W = 6
) (
  input  logic          i_cpu_ck,
  input  logic          i_cpu_rst_n,
  input  logic          i_cs_n,
  input  logic          i_ras_n,
  input  logic          i_cas_n,
  input  logic          i_we_n,
  input  logic [2:0]    i_ba,
  input  logic [13:0]   i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_rvalid,
  output logic [7:0]    o_bank_open,
  output logic          o_viol,
  output logic [2:0]    o_viol_code
);
  // Burst base = {bank, row, column bits above the beat}; beat index appended below.
  localparam int BASE_W = 3 + MEM_ROW_W + MEM_COL_W - 3;
  localparam int IW     = BASE_W + 3;

  typedef enum logic [2:0] {
    C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
    C_WR  = 3'b100, C_RD  = 3'b101, C_ZQ  = 3'b110, C_NOP = 3'b111
  } cmd_e;

  logic [7:0]                r_open;
  logic [7:0][MEM_ROW_W-1:0] r_row;
  logic [3:0]                r_rd_since, r_wr_since;
  logic [CL-2:0]             r_rd_vld_pipe;
  logic [CWL-2:0]            r_wr_vld_pipe;
  logic [BASE_W-1:0]         r_rd_pbase [0:CL-2];
  logic [BASE_W-1:0]         r_wr_pbase [0:CWL-2];
  logic                      r_rd_on, r_wr_on;
  logic [2:0]                r_rd_beat, r_wr_beat;
  logic [BASE_W-1:0]         r_rd_base, r_wr_base;
  logic [DW-1:0]             r_mem [0:(1<<IW)-1];

  cmd_e              w_cmd;
  logic              w_act, w_rd, w_wr, w_pre, w_refmrs;
  logic              w_bank_on, w_trcd_bad;
  logic [2:0]        w_code;
  logic              w_ok, w_rd_go, w_wr_go;
  logic [BASE_W-1:0] w_base;
  logic              w_unused;

  // Deselected cycles and ZQ decode as NOP
  assign w_cmd     = i_cs_n ? C_NOP : cmd_e'({i_ras_n, i_cas_n, i_we_n});
  assign w_act     = (w_cmd == C_ACT);
  assign w_rd      = (w_cmd == C_RD);
  assign w_wr      = (w_cmd == C_WR);
  assign w_pre     = (w_cmd == C_PRE);
  assign w_refmrs  = (w_cmd == C_REF) || (w_cmd == C_MRS);
  assign w_bank_on = r_open[i_ba];
  assign w_base    = {i_ba, r_row[i_ba], i_addr[MEM_COL_W-1:3]};
  assign w_unused  = ^i_addr;

`ifdef DDR3_RESP_TIMING_CHK_EN
  localparam int TW = $clog2(TRCD + 1);
  logic [7:0][TW-1:0] r_trcd;

  // Per-bank tRCD countdown, reloaded on every accepted ACT
  always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
    if (!i_cpu_rst_n) begin
      r_trcd <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (w_act && w_ok && (i_ba == 3'(b))) r_trcd[b] <= TW'(TRCD - 1);
        else if (r_trcd[b] != '0)            r_trcd[b] <= r_trcd[b] - 1'b1;
      end
    end
  end
  assign w_trcd_bad = (r_trcd[i_ba] != '0);
`else
  localparam int unused_trcd = TRCD;
  assign w_trcd_bad = 1'b0;
`endif

  // Violation classification; rule order gives lowest-code priority
  always_comb begin
    w_code = 3'd0;
    if ((w_rd || w_wr) && !w_bank_on)                                     w_code = 3'd1;
    else if (w_act && w_bank_on)                                          w_code = 3'd2;
    else if (w_refmrs && (r_open != '0))                                  w_code = 3'd3;
    else if ((w_rd && r_rd_since < 4'd8) || (w_wr && r_wr_since < 4'd8))  w_code = 3'd4;
    else if ((w_rd || w_wr) && w_trcd_bad)                                w_code = 3'd5;
  end
  assign w_ok    = (w_code == 3'd0);
  assign w_rd_go = w_rd && w_ok;
  assign w_wr_go = w_wr && w_ok;

  // Bank open/row tracking; auto-precharge closes the bank as the burst is launched
  always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
    if (!i_cpu_rst_n) begin
      r_open <= '0;
      r_row  <= '0;
    end else begin
      if (w_act && w_ok) begin
        r_open[i_ba] <= 1'b1;
        r_row[i_ba]  <= i_addr[MEM_ROW_W-1:0];
      end
      if (w_pre) begin
        if (i_addr[10]) r_open       <= '0;
        else            r_open[i_ba] <= 1'b0;
      end
      if ((w_rd_go || w_wr_go) && i_addr[10]) r_open[i_ba] <= 1'b0;
    end
  end
  assign o_bank_open = r_open;

  // Sticky violation flag; code holds the first offence only
  always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
    if (!i_cpu_rst_n) begin
      o_viol      <= 1'b0;
      o_viol_code <= 3'd0;
    end else if (!w_ok && !o_viol) begin
      o_viol      <= 1'b1;
      o_viol_code <= w_code;
    end
  end

  // Cycles since last accepted RD / WR, saturating at 8 (8 = no burst conflict)
  always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
    if (!i_cpu_rst_n) begin
      r_rd_since <= 4'd8;
      r_wr_since <= 4'd8;
    end else begin
      if (w_rd_go)                 r_rd_since <= 4'd1;
      else if (r_rd_since < 4'd8)  r_rd_since <= r_rd_since + 4'd1;
      if (w_wr_go)                 r_wr_since <= 4'd1;
      else if (r_wr_since < 4'd8)  r_wr_since <= r_wr_since + 4'd1;
    end
  end

  // Latency delay lines: valid bits, cleared by reset
  always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
    if (!i_cpu_rst_n) begin
      r_rd_vld_pipe <= '0;
      r_wr_vld_pipe <= '0;
    end else begin
      r_rd_vld_pipe[0] <= w_rd_go;
      r_wr_vld_pipe[0] <= w_wr_go;
      for (int i = 1; i < CL - 1; i++)  r_rd_vld_pipe[i] <= r_rd_vld_pipe[i-1];
      for (int i = 1; i < CWL - 1; i++) r_wr_vld_pipe[i] <= r_wr_vld_pipe[i-1];
    end
  end

  // Latency delay lines: burst base addresses, qualified by the valid bits
  always_ff @(posedge i_cpu_ck) begin
    r_rd_pbase[0] <= w_base;
    r_wr_pbase[0] <= w_base;
    for (int i = 1; i < CL - 1; i++)  r_rd_pbase[i] <= r_rd_pbase[i-1];
    for (int i = 1; i < CWL - 1; i++) r_wr_pbase[i] <= r_wr_pbase[i-1];
  end

  // Read burster: fetch the current beat and register it onto o_rdata
  always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
    if (!i_cpu_rst_n) begin
      r_rd_on   <= 1'b0;
      r_rd_beat <= 3'd0;
      r_rd_base <= '0;
      o_rvalid  <= 1'b0;
      o_rdata   <= '0;
    end else begin
      o_rvalid <= r_rd_on;
      o_rdata  <= r_rd_on ? r_mem[{r_rd_base, r_rd_beat}] : '0;
      if (r_rd_on) begin
        r_rd_beat <= r_rd_beat + 3'd1;
        if (r_rd_beat == 3'd7) r_rd_on <= 1'b0;
      end
      // A new burst may start on the same edge the previous one drives beat 7
      if (r_rd_vld_pipe[CL-2]) begin
        r_rd_on   <= 1'b1;
        r_rd_beat <= 3'd0;
        r_rd_base <= r_rd_pbase[CL-2];
      end
    end
  end

  // Write burster: beat counter for the active write burst
  always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
    if (!i_cpu_rst_n) begin
      r_wr_on   <= 1'b0;
      r_wr_beat <= 3'd0;
      r_wr_base <= '0;
    end else begin
      if (r_wr_on) begin
        r_wr_beat <= r_wr_beat + 3'd1;
        if (r_wr_beat == 3'd7) r_wr_on <= 1'b0;
      end
      if (r_wr_vld_pipe[CWL-2]) begin
        r_wr_on   <= 1'b1;
        r_wr_beat <= 3'd0;
        r_wr_base <= r_wr_pbase[CWL-2];
      end
    end
  end

  // Storage array (not reset): write beat lands on the edge it is sampled
  always_ff @(posedge i_cpu_ck) begin
    if (r_wr_on) r_mem[{r_wr_base, r_wr_beat}] <= i_wdata;
  end
endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Scoreboard bench for ddr3_cmd_responder: the stimulus thread pushes the
// expected read beats (data + cycle) and a monitor pops them on o_rvalid.
module tb_ddr3_cmd_responder;
  localparam int CL = 5, CWL = 4;
  localparam logic [2:0] MRS = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011,
                         WR  = 3'b100, RD  = 3'b101, NOP = 3'b111;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [2:0]  ba = '0;
  logic [13:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        rvalid, viol;
  logic [7:0]  bank_open;
  logic [2:0]  viol_code;

  typedef struct { logic [15:0] d; int cyc; } exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0, bad = 0;

  ddr3_cmd_responder dut (
    .i_cpu_ck(clk), .i_cpu_rst_n(rst_n), .i_cs_n(cs_n), .i_ras_n(ras_n),
    .i_cas_n(cas_n), .i_we_n(we_n), .i_ba(ba), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .o_rvalid(rvalid), .o_bank_open(bank_open),
    .o_viol(viol), .o_viol_code(viol_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One command per call, driven on the falling edge, sampled at the next rising edge
  task automatic cmd(input logic [2:0] c, input logic [2:0] b, input logic [13:0] a);
    @(negedge clk);
    cs_n = (c == NOP);
    {ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
  endtask

  task automatic nop(input int n);
    repeat (n) cmd(NOP, 3'd0, 14'd0);
  endtask

  // Drives 8 beats so that they are sampled CWL..CWL+7 cycles after the WR edge
  task automatic send_wdata(input logic [15:0] base);
    repeat (CWL) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      if (b != 0) @(negedge clk);
      wdata = base + 16'(b);
    end
    @(negedge clk);
    wdata = '0;
  endtask

  // Called right after the RD cmd() returns; RD is sampled at cycle cyc+1
  task automatic push_rd(input logic [15:0] base, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back('{base + 16'(b), cyc + 1 + CL + b});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cs_n = 1'b1; {ras_n, cas_n, we_n} = NOP;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every valid beat must match the head of the scoreboard in data and cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rvalid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got %0h at cyc %0d want none", rdata, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (rdata !== e.d || cyc != e.cyc) begin
            bad++;
            $display("FAIL rd_beat: got %0h at cyc %0d want %0h at cyc %0d", rdata, cyc, e.d, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bank_open", bank_open, 0);
    chk("rst_viol", viol, 0);
    chk("rst_code", viol_code, 0);
    rst_n = 1'b1;

    // Write burst then read it back 10 cycles after the WR
    cmd(ACT, 3'd2, 14'h5);
    nop(3);
    cmd(WR, 3'd2, 14'h10);
    fork send_wdata(16'hA000); join_none
    nop(9);
    cmd(RD, 3'd2, 14'h10);
    push_rd(16'hA000, 8);
    nop(CL + 10);
    chk("wr_rd_viol", viol, 0);
    chk("wr_rd_bank_open", bank_open, 8'h04);
    chk("wr_rd_drained", exp_q.size(), 0);

    // Reset asserted while beat 3 of a read burst is on the bus
    cmd(RD, 3'd2, 14'h10);
    push_rd(16'hA000, 4);
    nop(1 + CL + 3);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_bank_open", bank_open, 0);
    chk("midrst_viol", viol, 0);
    @(negedge clk) rst_n = 1'b1;
    nop(12);
    chk("midrst_beats", exp_q.size(), 0);

    // PRE-all then REF on the next cycle; PRE to idle bank; single-bank PRE
    cmd(ACT, 3'd0, 14'h1);
    cmd(ACT, 3'd1, 14'h2);
    nop(1);
    chk("two_open", bank_open, 8'h03);
    cmd(PRE, 3'd0, 14'h400);
    cmd(REF, 3'd0, 14'h0);
    nop(1);
    chk("pre_all_open", bank_open, 0);
    chk("ref_legal_viol", viol, 0);
    cmd(PRE, 3'd5, 14'h0);
    nop(1);
    chk("pre_idle_viol", viol, 0);
    cmd(ACT, 3'd3, 14'h7);
    nop(1);
    chk("act3_open", bank_open, 8'h08);
    cmd(PRE, 3'd3, 14'h0);
    nop(1);
    chk("pre3_open", bank_open, 0);
    cmd(ACT, 3'd6, 14'h0);
    cmd(MRS, 3'd0, 14'h0);
    nop(1);
    chk("mrs_open_code", viol_code, 3);
    chk("mrs_open_bank", bank_open, 8'h40);

    // RD to idle bank, then double ACT keeps the first code
    do_reset();
    cmd(RD, 3'd4, 14'h0);
    nop(1);
    chk("rd_idle_viol", viol, 1);
    chk("rd_idle_code", viol_code, 1);
    cmd(ACT, 3'd4, 14'h0);
    cmd(ACT, 3'd4, 14'h0);
    nop(CL + 10);
    chk("dbl_act_code", viol_code, 1);
    chk("dbl_act_viol", viol, 1);
    chk("dbl_act_open", bank_open, 8'h10);

    // Second RD only 4 cycles after the first is rejected
    do_reset();
    cmd(ACT, 3'd1, 14'h2);
    nop(3);
    cmd(WR, 3'd1, 14'h08);
    fork send_wdata(16'hB000); join_none
    nop(11);
    cmd(RD, 3'd1, 14'h08);
    push_rd(16'hB000, 8);
    nop(3);
    cmd(RD, 3'd1, 14'h08);
    nop(1);
    chk("overlap_viol", viol, 1);
    chk("overlap_code", viol_code, 4);
    nop(CL + 12);
    chk("overlap_beats", exp_q.size(), 0);

    // RD one cycle after ACT (tRCD)
    do_reset();
    cmd(ACT, 3'd0, 14'h1);
    nop(3);
    cmd(WR, 3'd0, 14'h0);
    fork send_wdata(16'hC000); join_none
    nop(12);
    cmd(PRE, 3'd0, 14'h0);
    nop(1);
    cmd(ACT, 3'd0, 14'h1);
    cmd(RD, 3'd0, 14'h0);
`ifdef DDR3_RESP_TIMING_CHK_EN
    nop(CL + 12);
    chk("trcd_viol", viol, 1);
    chk("trcd_code", viol_code, 5);
`else
    push_rd(16'hC000, 8);
    nop(CL + 12);
    chk("trcd_viol", viol, 0);
    chk("trcd_code", viol_code, 0);
`endif
    chk("trcd_beats", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
